// File: rtl/store_rmw_unit.sv
// Store path for a data memory without byte strobes: sw writes directly, sb/sh read-modify-write.
// Optional misaligned-store trapping is enabled by defining STORE_MISALIGN_TRAP_EN.
module store_rmw_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StoreReq,
  input  logic [2:0]  StoreSize,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        StoreDone,
  output logic        StoreMisalign,
  output logic [31:0] MemAddr,
  output logic        MemRe,
  input  logic [31:0] MemRdata,
  output logic        MemWe,
  output logic [31:0] MemWdata
);

  localparam int unsigned CW = 3;
  localparam logic [2:0] SZ_W = 3'b000;
  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b011;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DROP} state_t;

  state_t          state, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      size_q, size_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic            legal;
  logic            fault;
  logic [31:0]     merged;

  assign legal = (StoreSize == SZ_W) || (StoreSize == SZ_B) || (StoreSize == SZ_H);

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign fault = ((StoreSize == SZ_W) && (AddrM[1:0] != 2'b00)) ||
                 ((StoreSize == SZ_H) && AddrM[0]);
  assign StoreMisalign = mis_q;
`else
  assign fault = 1'b0;
  assign StoreMisalign = 1'b0;
`endif

  // Insert the captured byte/halfword into the word returned by memory
  always_comb begin
    merged = MemRdata;
    if (size_q == SZ_B) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (StoreReq) begin
          addr_d = AddrM;
          data_d = WriteDataM;
          size_d = StoreSize;
          if (!legal || fault) begin
            state_d = DROP;
            done_d  = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_d   = fault;
`endif
          end else if (StoreSize == SZ_W) begin
            state_d = WRITE;
            we_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
          end
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = CW'(READ_LATENCY);
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          data_d  = merged;
          state_d = WRITE;
          we_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      re_q   <= re_d;
      we_q   <= we_d;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q  <= mis_d;
`endif
    end
  end

  assign StoreDone = done_q;
  assign MemRe     = re_q;
  assign MemWe     = we_q;
  assign MemAddr   = {addr_q[31:2], 2'b00};
  assign MemWdata  = data_q;
  assign StallM    = StoreReq & ~done_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (read latency 1 and 3) each backed by a
// small latency-accurate memory, checked against a byte-mask reference of memory contents.
module tb_store_rmw_unit;

  localparam int unsigned LAT0   = 1;
  localparam int unsigned LAT1   = 3;
  localparam int          BUDGET = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req[2];
  logic [2:0]  sz_i[2];
  logic [31:0] a_i[2];
  logic [31:0] d_i[2];
  logic [31:0] rdata[2];
  logic        stall_o[2];
  logic        done_o[2];
  logic        mis_o[2];
  logic        re_o[2];
  logic        we_o[2];
  logic [31:0] maddr[2];
  logic [31:0] wdata_o[2];

  logic [7:0]  vpipe[2];
  logic [31:0] tmem[2][64];
  logic [31:0] model[2][64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_rmw_unit #(.READ_LATENCY(LAT0)) dut0 (
    .clk(clk), .reset_n(reset_n), .StoreReq(req[0]), .StoreSize(sz_i[0]),
    .AddrM(a_i[0]), .WriteDataM(d_i[0]), .StallM(stall_o[0]), .StoreDone(done_o[0]),
    .StoreMisalign(mis_o[0]), .MemAddr(maddr[0]), .MemRe(re_o[0]), .MemRdata(rdata[0]),
    .MemWe(we_o[0]), .MemWdata(wdata_o[0])
  );

  store_rmw_unit #(.READ_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset_n(reset_n), .StoreReq(req[1]), .StoreSize(sz_i[1]),
    .AddrM(a_i[1]), .WriteDataM(d_i[1]), .StallM(stall_o[1]), .StoreDone(done_o[1]),
    .StoreMisalign(mis_o[1]), .MemAddr(maddr[1]), .MemRe(re_o[1]), .MemRdata(rdata[1]),
    .MemWe(we_o[1]), .MemWdata(wdata_o[1])
  );

  // Memory returns the real word only in the cycle READ_LATENCY after MemRe, garbage otherwise
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) vpipe[k] <= '0;
      else          vpipe[k] <= {vpipe[k][6:0], re_o[k]};
      if (we_o[k]) tmem[k][maddr[k][7:2]] <= wdata_o[k];
    end
  end

  assign rdata[0] = vpipe[0][LAT0-1] ? tmem[0][maddr[0][7:2]] : ~tmem[0][maddr[0][7:2]];
  assign rdata[1] = vpipe[1][LAT1-1] ? tmem[1][maddr[1][7:2]] : ~tmem[1][maddr[1][7:2]];

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [2:0] sz,
                                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    case (sz)
      3'b001:  begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh; end
      3'b011:  begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF << sh; end
      default: begin sh = 0;                mask = 32'hFFFF_FFFF;       end
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input int k, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] wcap);
    int          lat, re_n, we_n, re_c, we_c, done_c, idx;
    logic        illegal, misal, drop, rmw, mis_seen;
    logic [31:0] exp_w;
    idx     = int'(a[7:2]);
    illegal = !(sz == 3'b000 || sz == 3'b001 || sz == 3'b011);
    misal   = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    misal   = !illegal && ((sz == 3'b000 && a[1:0] != 2'b00) || (sz == 3'b011 && a[0]));
`endif
    drop     = illegal || misal;
    rmw      = !drop && (sz != 3'b000);
    lat      = rmw ? 2 + lat_of(k) : 1;
    exp_w    = ref_word(model[k][idx], sz, a, d);
    re_n     = 0; we_n = 0; re_c = -1; we_c = -1; done_c = -1;
    mis_seen = 1'b0;
    wcap     = '0;
    @(negedge clk);
    req[k] = 1'b1; sz_i[k] = sz; a_i[k] = a; d_i[k] = d;
    for (int c = 0; c < BUDGET; c++) begin
      #1;
      if (re_o[k]) begin re_n++; re_c = c; end
      if (we_o[k]) begin we_n++; we_c = c; wcap = wdata_o[k]; end
      if (c > 0) chk("mem_addr", maddr[k], {a[31:2], 2'b00});
      chk("stall", stall_o[k], c < lat);
      if (done_o[k]) begin
        done_c   = c;
        mis_seen = mis_o[k];
        break;
      end
      @(negedge clk);
    end
    req[k] = 1'b0;
    chk("done_cycle", done_c, lat);
    chk("misalign", mis_seen, misal);
    chk("we_count", we_n, drop ? 0 : 1);
    chk("re_count", re_n, rmw ? 1 : 0);
    if (rmw) chk("re_cycle", re_c, 1);
    if (!drop) begin
      chk("we_cycle", we_c, lat);
      chk("wdata", wcap, exp_w);
      model[k][idx] = exp_w;
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  sz;
    int          k;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; sz_i[i] = '0; a_i[i] = '0; d_i[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_done", done_o[i], 1'b0);
      chk("rst_re", re_o[i], 1'b0);
      chk("rst_we", we_o[i], 1'b0);
      chk("rst_mis", mis_o[i], 1'b0);
      chk("rst_stall", stall_o[i], 1'b0);
      chk("rst_addr", maddr[i], 32'h0);
      chk("rst_wdata", wdata_o[i], 32'h0);
    end
    reset_n = 1'b1;

    // Fill both memories with full-word stores so every later read has known contents
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) do_store(i, 3'b000, 32'(j * 4), $urandom, w);

    do_store(0, 3'b000, 32'h100, 32'hDEAD_BEEF, w);
    chk("t1_wdata", w, 32'hDEAD_BEEF);

    do_store(0, 3'b000, 32'h100, 32'h1122_3344, w);
    do_store(0, 3'b001, 32'h102, 32'h0000_00AA, w);
    chk("t2_wdata", w, 32'h11AA_3344);

    do_store(1, 3'b000, 32'h104, 32'h5566_7788, w);
    do_store(1, 3'b011, 32'h106, 32'h0000_BEEF, w);
    chk("t3_wdata", w, 32'hBEEF_7788);

    for (int i = 0; i < 2; i++) begin
      do_store(i, 3'b111, 32'h108, 32'h1234_5678, w);
      do_store(i, 3'b010, 32'h10C, 32'h1234_5678, w);
      do_store(i, 3'b100, 32'h110, 32'h1234_5678, w);
      do_store(i, 3'b000, 32'h101, 32'hCAFE_F00D, w);
      do_store(i, 3'b011, 32'h113, 32'h0000_A5A5, w);
      do_store(i, 3'b011, 32'h111, 32'h0000_5A5A, w);
    end

    // Reset pulled during the wait for read data: store aborts and never writes
    @(negedge clk);
    req[1] = 1'b1; sz_i[1] = 3'b001; a_i[1] = 32'h41; d_i[1] = 32'h77;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_done", done_o[1], 1'b0);
    chk("abort_re", re_o[1], 1'b0);
    chk("abort_we", we_o[1], 1'b0);
    chk("abort_addr", maddr[1], 32'h0);
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("abort_no_we", we_o[1], 1'b0);
    end
    reset_n = 1'b1;
    do_store(1, 3'b000, 32'h44, 32'h0BAD_CAFE, w);
    chk("post_abort_sw", w, 32'h0BAD_CAFE);

    for (int i = 0; i < 2; i++) begin
      do_store(i, 3'b000, 32'h20, 32'h0, w);
      do_store(i, 3'b001, 32'h21, 32'h5A, w);
      do_store(i, 3'b001, 32'h23, 32'hC3, w);
      chk("b2b_word", w, 32'hC300_5A00);
    end

    for (int n = 0; n < 160; n++) begin
      k = int'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0, 1:    sz = 3'b000;
        2, 3:    sz = 3'b001;
        4, 5:    sz = 3'b011;
        default: sz = 3'(3'b100 + 3'($urandom_range(0, 3)));
      endcase
      do_store(k, sz, 32'($urandom_range(0, 255)), $urandom, w);
    end

    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) chk("final_mem", tmem[i][j], model[i][j]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
